// File: rtl/multi_src_buf_ctrl.sv
// rtl/multi_src_buf_ctrl.sv - multi-source channel selector feeding a single word FIFO
module multi_src_buf_ctrl #(
  parameter  int N_SRC  = 2,
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int SW     = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        start,
  input  logic                    stop,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    parity,
  output logic [SW-1:0]           active_src,
  output logic [1:0]              state,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic                    empty
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COMM  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t              state_q;
  logic [SW-1:0]       active_q;
  logic [N_SRC-1:0]    start_prev;
  logic                stop_prev;
  logic                edge_armed;
  logic [N_SRC-1:0]    start_rise;
  logic                stop_rise;
  logic [SW-1:0]       first_idx;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count_q;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Previous-value registers for edge detection. edge_armed stays low for the
  // first edge after reset so that a level already high at release is taken
  // as the baseline rather than as a fresh rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_prev <= '0;
      stop_prev  <= 1'b0;
      edge_armed <= 1'b0;
    end else begin
      start_prev <= start;
      stop_prev  <= stop;
      edge_armed <= 1'b1;
    end
  end

  assign start_rise = edge_armed ? (start & ~start_prev) : '0;
  assign stop_rise  = edge_armed & stop & ~stop_prev;

  // Lowest-index rising start channel wins when several rise together.
  always_comb begin
    first_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (start_rise[i]) first_idx = SW'(i);
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Only the selected channel sees ready, and only while room remains.
  always_comb begin
    src_ready = '0;
    if (state_q == ST_COMM && !full) src_ready[active_q] = 1'b1;
  end

  assign push = src_valid[active_q] & src_ready[active_q];
  assign pop  = out_valid & out_ready;

  // Channel-selection FSM; stop takes priority over the full/not-full moves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|start_rise) begin
            state_q  <= ST_COMM;
            active_q <= first_idx;
          end
        end
        ST_COMM: begin
          if (stop_rise)  state_q <= ST_DRAIN;
          else if (full)  state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (stop_rise)  state_q <= ST_DRAIN;
          else if (!full) state_q <= ST_COMM;
        end
        ST_DRAIN: begin
          if (empty)      state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; left uninitialised since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= src_data[active_q*DATA_W +: DATA_W];
  end

  assign out_valid  = ~empty;
  assign out_data   = empty ? '0 : mem[rd_ptr];
  assign parity     = ^out_data;
  assign active_src = active_q;
  assign state      = state_q;
  assign count      = count_q;

endmodule

// File: tb/tb_multi_src_buf_ctrl.sv
// tb/tb_multi_src_buf_ctrl.sv - randomized self-checking bench with queue-based reference model
module tb_multi_src_buf_ctrl;
  localparam int N_SRC = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SW    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [N_SRC-1:0]      start;
  logic                  stop;
  logic [N_SRC*DW-1:0]   src_data;
  logic [N_SRC-1:0]      src_valid;
  logic [N_SRC-1:0]      src_ready;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  parity;
  logic [SW-1:0]         active_src;
  logic [1:0]            state;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;

  multi_src_buf_ctrl #(.N_SRC(N_SRC), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity(parity), .active_src(active_src), .state(state),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO contents as a queue, FSM as a named state.
  logic [DW-1:0]    q[$];
  int               m_state;
  int               m_act;
  logic [N_SRC-1:0] m_sprev;
  logic             m_pprev;
  bit               m_armed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_act   = 0;
    m_sprev = '0;
    m_pprev = 1'b0;
    m_armed = 1'b0;
  endtask

  task automatic model_step();
    logic [N_SRC-1:0] rs;
    logic             rp;
    bit               mfull, mempty, do_push, do_pop;
    logic [DW-1:0]    word;
    rs      = m_armed ? (start & ~m_sprev) : '0;
    rp      = m_armed & stop & ~m_pprev;
    mfull   = (q.size() == DEPTH);
    mempty  = (q.size() == 0);
    do_push = (m_state == 1) && !mfull && src_valid[m_act];
    do_pop  = !mempty && out_ready;
    word    = src_data[m_act*DW +: DW];
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(word);
    case (m_state)
      0: if (rs != 0) begin
           for (int i = N_SRC - 1; i >= 0; i--) if (rs[i]) m_act = i;
           m_state = 1;
         end
      1: if (rp) m_state = 3; else if (mfull) m_state = 2;
      2: if (rp) m_state = 3; else if (!mfull) m_state = 1;
      default: if (mempty) m_state = 0;
    endcase
    m_sprev = start;
    m_pprev = stop;
    m_armed = 1'b1;
  endtask

  // One clock: inputs were set beforehand, the model follows the edge, then
  // the caller may change inputs 1 time unit later.
  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic set_src(input int ch, input int val);
    src_data[ch*DW +: DW] = DW'(val);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        logic [DW-1:0]    e_data;
        logic [N_SRC-1:0] e_rdy;
        e_data = (q.size() != 0) ? q[0] : '0;
        e_rdy  = '0;
        if (m_state == 1 && q.size() != DEPTH) e_rdy[m_act] = 1'b1;
        chk("state",      32'(state),      32'(m_state));
        chk("active_src", 32'(active_src), 32'(m_act));
        chk("count",      32'(count),      32'(q.size()));
        chk("full",       32'(full),       32'(q.size() == DEPTH));
        chk("empty",      32'(empty),      32'(q.size() == 0));
        chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
        chk("out_data",   32'(out_data),   32'(e_data));
        chk("parity",     32'(parity),     32'(^e_data));
        chk("src_ready",  32'(src_ready),  32'(e_rdy));
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_state",     32'(state),      0);
    chk("rst_active",    32'(active_src), 0);
    chk("rst_count",     32'(count),      0);
    chk("rst_out_valid", 32'(out_valid),  0);
    chk("rst_out_data",  32'(out_data),   0);
    chk("rst_parity",    32'(parity),     0);
    chk("rst_src_ready", 32'(src_ready),  0);
    chk("rst_empty",     32'(empty),      1);
    chk("rst_full",      32'(full),       0);
  endtask

  initial begin
    int rdy_pct;
    reset = 1'b1; start = '0; stop = 1'b0; src_data = '0;
    src_valid = '0; out_ready = 1'b0;
    model_reset();
    #1;
    chk_reset_values();
    tick(); tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    tick(); tick();

    // Channel 1 selected, three words buffered
    start = 2'b10; tick();
    src_valid = 2'b10;
    for (int w = 1; w <= 3; w++) begin set_src(1, w); tick(); end
    src_valid = '0;
    chk("d1_state",  32'(state),      1);
    chk("d1_active", 32'(active_src), 1);
    chk("d1_count",  32'(count),      3);
    chk("d1_data",   32'(out_data),   32'h0001);
    chk("d1_parity", 32'(parity),     1);

    // Fill to full, move to WAIT, one pop returns to COMM
    src_valid = 2'b10;
    for (int w = 4; w <= 8; w++) begin set_src(1, w); tick(); end
    src_valid = '0;
    chk("d2_full",  32'(full),      1);
    chk("d2_ready", 32'(src_ready), 0);
    tick();
    chk("d2_wait",  32'(state), 2);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("d2_count", 32'(count), 7);
    tick();
    chk("d2_comm",  32'(state), 1);

    // Refill, stop while full, drain in order
    src_valid = 2'b10; set_src(1, 9); tick(); src_valid = '0;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("d3_drain", 32'(state), 3);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("d3_order", 32'(out_data), 32'(2 + k));
      tick();
    end
    out_ready = 1'b0;
    chk("d3_empty", 32'(empty), 1);
    tick();
    chk("d3_idle",  32'(state), 0);

    // Simultaneous starts pick channel 0; later start rise ignored
    start = 2'b00; tick();
    start = 2'b11; tick();
    chk("d4_active", 32'(active_src), 0);
    start = 2'b01; tick();
    start = 2'b11; tick();
    chk("d4_keep",   32'(active_src), 0);
    chk("d4_state",  32'(state),      1);

    // Steady push+pop at occupancy 4 across pointer wrap
    src_valid = 2'b01;
    for (int w = 0; w < 4; w++) begin set_src(0, 100 + w); tick(); end
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("d5_head", 32'(out_data), 32'(100 + k));
      set_src(0, 104 + k);
      tick();
    end
    chk("d5_count", 32'(count), 4);
    out_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin set_src(0, 200 + w); tick(); end
    src_valid = '0;
    tick();
    chk("d6_wait", 32'(state), 2);

    // Asynchronous reset in WAIT with start held high throughout
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk_reset_values();
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("d6_held", 32'(state), 0);
    start = 2'b00; tick();
    start = 2'b01; tick();
    chk("d6_retrig", 32'(state), 1);

    // Randomized traffic
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < N_SRC; i++)
        if ($urandom_range(0, 7) == 0) start[i] = ~start[i];
      if ($urandom_range(0, 23) == 0) stop = ~stop;
      src_valid = N_SRC'($urandom);
      for (int i = 0; i < N_SRC; i++) set_src(i, int'($urandom_range(0, 65535)));
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if ($urandom_range(0, 599) == 0) begin
        #3;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
